// File: rtl/alu_pipe.sv
// alu_pipe: pipelined WIDTH-bit ALU with a 2*WIDTH-bit result and valid/ready on both sides.
// Define ALU_PIPE_DIV_EN to build the iterative restoring divider behind opcodes 10 (DIV) and 11 (MOD).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               zero,
  output logic               err
);
  localparam int W2    = 2 * WIDTH;
  localparam int SHL_W = $clog2(W2);
  localparam int SHR_W = $clog2(WIDTH);

  // Handshake: an operation moves in on a rising edge with in_valid && in_ready, and a result
  // moves out on a rising edge with out_valid && out_ready. The whole pipe advances together
  // (adv), so a stalled output freezes every stage and out/zero/err stay stable.
  logic               adv;
  logic               div_busy;
  logic               div_start;
  logic               div_done;
  logic [W2-1:0]      div_res;
  logic               div_err;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [3:0]         s1_s;

  logic               s2_valid;
  logic [W2-1:0]      s2_res;
  logic               s2_err;

  logic [W2-1:0]      xa;
  logic [W2-1:0]      xb;
  logic [W2-1:0]      alu_res;
  logic               alu_err;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !div_busy && !rst;

  assign xa = {{WIDTH{1'b0}}, s1_a};
  assign xb = {{WIDTH{1'b0}}, s1_b};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (s1_s)
      4'd0:    alu_res = xa + xb;
      4'd1:    alu_res = xa - xb;
      4'd2:    alu_res = xa * xb;
      4'd3:    alu_res = xa & xb;
      4'd4:    alu_res = xa | xb;
      4'd5:    alu_res = xa ^ xb;
      4'd6:    alu_res = {{WIDTH{1'b0}}, ~s1_a};
      4'd7:    alu_res = xa << s1_b[SHL_W-1:0];
      4'd8:    alu_res = xa >> s1_b[SHR_W-1:0];
      4'd9:    alu_res = (s1_a == s1_b) ? W2'(0) : ((s1_a < s1_b) ? W2'(1) : W2'(2));
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_DIV_EN
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       div_state;
  div_state_t       div_state_nxt;
  logic [CW-1:0]    div_cnt;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_den;
  logic             div_is_mod;
  logic             s1_is_div;
  logic             div_last;
  logic             div_step;
  logic             div_ge;
  logic [WIDTH-1:0] div_low;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  // A divide waiting in stage 1 already blocks new input so nothing can overtake it.
  assign s1_is_div = s1_valid && ((s1_s == 4'd10) || (s1_s == 4'd11));
  assign div_busy  = (div_state == DIV_BUSY) || s1_is_div;
  assign div_start = (div_state == DIV_IDLE) && adv && s1_is_div;
  assign div_last  = (div_cnt == CW'(WIDTH - 1));
  assign div_step  = (div_state == DIV_BUSY) && (!div_last || adv);
  assign div_done  = div_step && div_last;

  // Restoring step; the shifted-out remainder MSB means the partial remainder is >= 2^WIDTH.
  assign div_low     = {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
  assign div_ge      = div_rem[WIDTH-1] || (div_low >= div_den);
  assign div_rem_nxt = div_ge ? (div_low - div_den) : div_low;
  assign div_quo_nxt = {div_quo[WIDTH-2:0], div_ge};
  assign div_res     = {{WIDTH{1'b0}}, (div_is_mod ? div_rem_nxt : div_quo_nxt)};
  assign div_err     = (div_den == '0);

  always_comb begin
    div_state_nxt = div_state;
    case (div_state)
      DIV_IDLE: if (div_start) div_state_nxt = DIV_BUSY;
      DIV_BUSY: if (div_done)  div_state_nxt = DIV_IDLE;
      default:  div_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state  <= DIV_IDLE;
      div_cnt    <= '0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_den    <= '0;
      div_is_mod <= 1'b0;
    end else begin
      div_state <= div_state_nxt;
      if (div_start) begin
        div_cnt    <= '0;
        div_quo    <= s1_a;
        div_rem    <= '0;
        div_den    <= s1_b;
        div_is_mod <= (s1_s == 4'd11);
      end else if (div_step) begin
        div_cnt <= div_cnt + CW'(1);
        div_quo <= div_quo_nxt;
        div_rem <= div_rem_nxt;
      end
    end
  end
`else
  assign div_busy  = 1'b0;
  assign div_start = 1'b0;
  assign div_done  = 1'b0;
  assign div_res   = '0;
  assign div_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_s      <= '0;
      s2_valid  <= 1'b0;
      s2_res    <= '0;
      s2_err    <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_a <= a;
        s1_b <= b;
        s1_s <= s;
      end
      if (div_done) begin
        s2_valid <= 1'b1;
        s2_res   <= div_res;
        s2_err   <= div_err;
      end else begin
        s2_valid <= s1_valid && !div_start;
        s2_res   <= alu_res;
        s2_err   <= alu_err;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out  <= s2_res;
        zero <= (s2_res == '0);
        err  <= s2_err;
      end
    end
  end
endmodule
